egg_timer_core: RTL and testbench
=================================

Name: egg_timer_core

Overview:
- Countdown engine for the egg timer: holds a MM:SS time as four BCD digits, lets the user set it, counts it down once per second, and raises an alarm at 00:00.
- Sits directly upstream of the BCD-to-7-segment decoders; each digit output drives one decoder instance.
- Every digit output is always a legal BCD value (0-9), so the decoders never see an illegal code.

Parameters:
- TICK_DIV, 50_000_000: clock cycles per one-second countdown tick (minimum 2).
- BLINK_DIV, 12_500_000: clock cycles per blank toggle in alarm (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  single-cycle pulse (already debounced/edge-detected upstream); run/pause/acknowledge.
- inc_min  in  1  single-cycle pulse; minutes +1 while setting.
- inc_sec  in  1  single-cycle pulse; seconds +1 while setting.
- clear  in  1  single-cycle pulse; time to 00:00, return to SET.
- min_tens  out  4  BCD 0-9.
- min_ones  out  4  BCD 0-9.
- sec_tens  out  4  BCD 0-5.
- sec_ones  out  4  BCD 0-9.
- running  out  1  high in RUN.
- alarm  out  1  high in ALARM.
- blank  out  1  display blank request for the downstream display drivers.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low. Reset forces state=SET, all digits 0, running=0, alarm=0, blank=0, and prescaler=0.
- All outputs are registered, with no combinational path from input to output. An input pulse at edge N takes effect at outputs after edge N.
- States: SET, RUN, PAUSE, ALARM.
- SET:
  - inc_sec adds 1 to SS; 59 wraps to 00 with no carry into minutes.
  - inc_min adds 1 to MM; 99 wraps to 00.
  - If inc_min and inc_sec arrive together, both apply.
  - start_stop: if time != 00:00, go to RUN and clear the prescaler. If time == 00:00, stay in SET (ignored).
- RUN:
  - The prescaler counts 0..TICK_DIV-1. At terminal count it emits a tick and wraps to 0.
  - The first decrement lands exactly TICK_DIV cycles after entering RUN.
  - Each tick does a BCD decrement with borrow chain sec_ones→sec_tens(5)→min_ones→min_tens. Example: 10:00 → 09:59.
  - A tick that makes the time 00:00 moves to ALARM on the same edge.
  - start_stop moves to PAUSE with the prescaler frozen.
  - inc_* pulses are ignored.
- PAUSE:
  - start_stop returns to RUN, resuming the prescaler from its frozen value.
  - inc_* pulses are ignored.
- ALARM:
  - alarm=1 and time holds at 00:00.
  - start_stop or clear moves to SET.
- Priority:
  - clear beats every other input in all states: SET, 00:00, prescaler=0.
  - In RUN, if start_stop and a tick coincide, the tick's decrement is applied and the state goes to PAUSE. If that decrement reaches 00:00, ALARM wins over PAUSE.
- running = (state==RUN). alarm = (state==ALARM).
- An assertion of reset_n mid-count discards the time completely; no state is retained.

Optional Feature:
- Macro: EGG_TIMER_BLINK_EN.
- Defined: in ALARM, a blink counter toggles blank every BLINK_DIV cycles, starting at blank=1 on the first ALARM cycle. blank=0 in all other states, and the blink counter is cleared on leaving ALARM.
- Undefined: blank is tied to 0, there is no blink counter, and BLINK_DIV is unused.

Decomposition:
- Package egg_timer_pkg holds:
  - the state enum (SET, RUN, PAUSE, ALARM);
  - a 4-bit bcd_t typedef;
  - constants SEC_TENS_MAX=5, DIGIT_MAX=9.
- One sub-module, egg_timer_prescaler:
  - ports: clk, reset_n, enable, restart, tick;
  - parameter DIV;
  - instantiated once for the tick and, under the macro, once for the blink.

Test Plan (TICK_DIV=4, BLINK_DIV=2):
- Reset → SET, 00:00, running=0, alarm=0, blank=0. start_stop at 00:00 → remains in SET.
- inc_sec ×61 → 00:01 (59 wraps to 00, minutes untouched). inc_min ×100 → 00:01 (99 wraps to 00).
- Set 01:00, start_stop → running=1; first decrement 4 cycles later gives 00:59; 00:58 follows 4 cycles after that.
- Set 00:02, run, pulse start_stop after 6 cycles → PAUSE at 00:01 with prescaler frozen; resume → 00:00 exactly 2 cycles later and alarm=1. With the macro defined, blank toggles every 2 cycles.
- In ALARM, pulse start_stop → SET with alarm=0 and blank=0. During RUN, pulse clear together with start_stop → SET, 00:00.
- Drop reset_n asynchronously mid-RUN at 37:15 → all outputs 0 immediately; after release, state=SET.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer countdown engine.
// Digits are BCD; the helpers wrap a single digit at a given maximum.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  function automatic bcd_t bcd_wrap_inc(input bcd_t d, input bcd_t max);
    return (d == max) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic bcd_t bcd_wrap_dec(input bcd_t d, input bcd_t max);
    return (d == 4'd0) ? max : d - 4'd1;
  endfunction

endpackage

// File: rtl/egg_timer_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled, emits tick on terminal count.
// restart forces the count back to zero and overrides enable.
module egg_timer_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == TERM);

endmodule

// File: rtl/egg_timer_core.sv
// MM:SS countdown engine: set, run/pause, alarm at 00:00, all outputs registered.
// Optional alarm blink on blank is enabled by defining EGG_TIMER_BLINK_EN.
module egg_timer_core
  import egg_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic       blank
);

  if (TICK_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
    $error("egg_timer_core: TICK_DIV and BLINK_DIV must be at least 2");
  end

  state_t state_q, state_d;
  bcd_t   mt_q, mo_q, st_q, so_q;
  bcd_t   mt_d, mo_d, st_d, so_d;
  bcd_t   mt_dec, mo_dec, st_dec, so_dec;
  logic   tick, time_zero, dec_zero;
  logic   b0, b1, b2;

  // Prescaler sits at zero in SET, so the first tick lands TICK_DIV cycles into RUN
  egg_timer_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_q == ST_RUN),
    .restart (clear || (state_q == ST_SET)),
    .tick    (tick)
  );

  assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);

  always_comb begin
    b0     = (so_q == 4'd0);
    b1     = b0 && (st_q == 4'd0);
    b2     = b1 && (mo_q == 4'd0);
    so_dec = bcd_wrap_dec(so_q, DIGIT_MAX);
    st_dec = b0 ? bcd_wrap_dec(st_q, SEC_TENS_MAX) : st_q;
    mo_dec = b1 ? bcd_wrap_dec(mo_q, DIGIT_MAX) : mo_q;
    mt_dec = b2 ? bcd_wrap_dec(mt_q, DIGIT_MAX) : mt_q;
    dec_zero = ({mt_dec, mo_dec, st_dec, so_dec} == 16'h0000);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_SET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_SET;
    end else begin
      unique case (state_q)
        ST_SET:   if (start_stop && !time_zero) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && dec_zero) state_d = ST_ALARM;
          else if (start_stop)  state_d = ST_PAUSE;
        end
        ST_PAUSE: if (start_stop) state_d = ST_RUN;
        ST_ALARM: if (start_stop) state_d = ST_SET;
        default:  state_d = ST_SET;
      endcase
    end
  end

  always_comb begin
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    if (clear) begin
      mt_d = 4'd0;
      mo_d = 4'd0;
      st_d = 4'd0;
      so_d = 4'd0;
    end else if (state_q == ST_SET) begin
      // Seconds wrap 59->00 without carrying into minutes
      if (inc_sec) begin
        so_d = bcd_wrap_inc(so_q, DIGIT_MAX);
        if (so_q == DIGIT_MAX) st_d = bcd_wrap_inc(st_q, SEC_TENS_MAX);
      end
      if (inc_min) begin
        mo_d = bcd_wrap_inc(mo_q, DIGIT_MAX);
        if (mo_q == DIGIT_MAX) mt_d = bcd_wrap_inc(mt_q, DIGIT_MAX);
      end
    end else if (state_q == ST_RUN && tick) begin
      mt_d = mt_dec;
      mo_d = mo_dec;
      st_d = st_dec;
      so_d = so_dec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mt_q <= 4'd0;
      mo_q <= 4'd0;
      st_q <= 4'd0;
      so_q <= 4'd0;
    end else begin
      mt_q <= mt_d;
      mo_q <= mo_d;
      st_q <= st_d;
      so_q <= so_d;
    end
  end

  always_comb begin
    min_tens = mt_q;
    min_ones = mo_q;
    sec_tens = st_q;
    sec_ones = so_q;
    running  = (state_q == ST_RUN);
    alarm    = (state_q == ST_ALARM);
  end

`ifdef EGG_TIMER_BLINK_EN
  logic blink_tick;
  logic blank_q, blank_d;

  egg_timer_prescaler #(.DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_q == ST_ALARM),
    .restart (state_q != ST_ALARM),
    .tick    (blink_tick)
  );

  // Blank comes up set on the first ALARM cycle, then toggles per blink tick
  always_comb begin
    blank_d = 1'b0;
    if (state_d == ST_ALARM) begin
      blank_d = (state_q != ST_ALARM) ? 1'b1 : (blank_q ^ blink_tick);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blank_q <= 1'b0;
    else          blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_egg_timer_core.sv
// Directed self-checking bench for egg_timer_core with TICK_DIV=4, BLINK_DIV=2.
// Blink expectations follow EGG_TIMER_BLINK_EN when it is defined for the build.
module tb_egg_timer_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_sec = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm, blank;

  int errors = 0;
  int checks = 0;

  egg_timer_core #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .inc_min    (inc_min),
    .inc_sec    (inc_sec),
    .clear      (clear),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .alarm      (alarm),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic r, input logic a, input logic b);
    chk({tag, ".running"}, {15'd0, running}, {15'd0, r});
    chk({tag, ".alarm"},   {15'd0, alarm},   {15'd0, a});
    chk({tag, ".blank"},   {15'd0, blank},   {15'd0, b});
  endtask

  // Drive the given pulses for exactly one rising edge; returns at the next falling edge
  task automatic pulse(input logic ss, input logic im, input logic is, input logic cl);
    start_stop = ss;
    inc_min    = im;
    inc_sec    = is;
    clear      = cl;
    @(negedge clk);
    start_stop = 1'b0;
    inc_min    = 1'b0;
    inc_sec    = 1'b0;
    clear      = 1'b0;
  endtask

  logic b_exp [0:4];

  initial begin
`ifdef EGG_TIMER_BLINK_EN
    b_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    b_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    repeat (2) @(negedge clk);
    chk("in_reset.time", disp(), 16'h0000);
    chk_flags("in_reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("after_reset.time", disp(), 16'h0000);
    chk_flags("after_reset", 1'b0, 1'b0, 1'b0);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_at_zero.time", disp(), 16'h0000);
    chk_flags("start_at_zero", 1'b0, 1'b0, 1'b0);

    // Seconds wrap without carry
    for (int i = 0; i < 59; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("inc_sec_59", disp(), 16'h0059);
    repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("inc_sec_61", disp(), 16'h0001);

    for (int i = 0; i < 99; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("inc_min_99", disp(), 16'h9901);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("inc_min_100", disp(), 16'h0001);

    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    chk("inc_both", disp(), 16'h0102);

    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_set", disp(), 16'h0000);

    // 01:00 countdown timing
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("set_0100", disp(), 16'h0100);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk_flags("run_0100", 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("run_0100_c3", disp(), 16'h0100);
    @(negedge clk);
    chk("run_0100_c4", disp(), 16'h0059);
    repeat (3) @(negedge clk);
    chk("run_0100_c7", disp(), 16'h0059);
    @(negedge clk);
    chk("run_0100_c8", disp(), 16'h0058);

    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    chk("clear_with_ss.time", disp(), 16'h0000);
    chk_flags("clear_with_ss", 1'b0, 1'b0, 1'b0);

    // Borrow chain 10:00 -> 09:59, inc ignored in RUN
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("set_1000", disp(), 16'h1000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    chk("run_inc_ignored", disp(), 16'h1000);
    repeat (2) @(negedge clk);
    chk("run_1000_c3", disp(), 16'h1000);
    @(negedge clk);
    chk("borrow_0959", disp(), 16'h0959);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_run", disp(), 16'h0000);

    // Pause/resume with frozen prescaler
    repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("set_0002", disp(), 16'h0002);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("run_0002_c4", disp(), 16'h0001);
    @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause.time", disp(), 16'h0001);
    chk_flags("pause", 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pause_hold", disp(), 16'h0001);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk_flags("resume", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("resume_c1", disp(), 16'h0001);
    @(negedge clk);
    chk("alarm.time", disp(), 16'h0000);
    chk_flags("alarm", 1'b0, 1'b1, b_exp[0]);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("alarm_blank_%0d", i), {15'd0, blank}, {15'd0, b_exp[i]});
      chk($sformatf("alarm_hold_%0d", i), disp(), 16'h0000);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk_flags("alarm_ack", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at 37:15
    for (int i = 0; i < 37; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("set_3715", disp(), 16'h3715);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("run_3715_pre", {15'd0, running}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.time", disp(), 16'h0000);
    chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst.time", disp(), 16'h0000);
    chk_flags("post_rst", 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_set", disp(), 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
